// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
// debounce_sync : synchronizer + debounce FSM giving a clean level and strobes
// Rev 1.0
// ============================================================================
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic notq_o,
  output logic rise_o,
  output logic fall_o
);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
  localparam bit               C_ONE_SHOT = (STABLE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   d_sync;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   q_q;
  logic                   q_d;
  logic                   notq_q;
  logic                   notq_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;

  // Pure flop chain: nothing but the shift between stages.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  assign d_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    notq_d  = notq_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      S_LOW: begin
        if (d_sync) begin
          if (C_ONE_SHOT) begin
            state_d = S_HIGH;
            cnt_d   = C_CNT_ZERO;
            q_d     = 1'b1;
            notq_d  = 1'b0;
            rise_d  = 1'b1;
          end else begin
            state_d = S_RISE;
            cnt_d   = C_CNT_ONE;
          end
        end else begin
          cnt_d = C_CNT_ZERO;
        end
      end

      S_RISE: begin
        if (!d_sync) begin
          state_d = S_LOW;
          cnt_d   = C_CNT_ZERO;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = C_CNT_ZERO;
          q_d     = 1'b1;
          notq_d  = 1'b0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_HIGH: begin
        if (!d_sync) begin
          if (C_ONE_SHOT) begin
            state_d = S_LOW;
            cnt_d   = C_CNT_ZERO;
            q_d     = 1'b0;
            notq_d  = 1'b1;
            fall_d  = 1'b1;
          end else begin
            state_d = S_FALL;
            cnt_d   = C_CNT_ONE;
          end
        end else begin
          cnt_d = C_CNT_ZERO;
        end
      end

      S_FALL: begin
        if (d_sync) begin
          state_d = S_HIGH;
          cnt_d   = C_CNT_ZERO;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = C_CNT_ZERO;
          q_d     = 1'b0;
          notq_d  = 1'b1;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = C_CNT_ZERO;
        q_d     = 1'b0;
        notq_d  = 1'b1;
      end
    endcase
  end

  // notq has its own flop (reset to 1) so it is a true registered complement.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      notq_q  <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      notq_q  <= notq_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q_o    = q_q;
  assign notq_o = notq_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// ============================================================================
// tb_debounce_sync : self-checking bench for debounce_sync
// Rev 1.0
// ============================================================================
module tb_debounce_sync;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int LAT    = SYNC + STABLE;
  localparam int W      = SYNC + STABLE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic d_i   = 1'b0;
  logic q_o;
  logic notq_o;
  logic rise_o;
  logic fall_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .CNT_W        (8)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .d_i    (d_i),
    .q_o    (q_o),
    .notq_o (notq_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  // Reference: the level flips once the last STABLE synchronized samples all
  // disagree with it; a synchronized sample is d_i as captured SYNC edges ago.
  logic [W-1:0] m_hist;
  logic         m_q;
  logic         m_rise;
  logic         m_fall;

  function automatic logic all_disagree(input logic [W-1:0] h, input logic lvl);
    for (int i = SYNC; i < W; i++) begin
      if (h[i] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist <= '0;
      m_q    <= 1'b0;
      m_rise <= 1'b0;
      m_fall <= 1'b0;
    end else begin
      m_hist <= {m_hist[W-2:0], d_i};
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      if (all_disagree({m_hist[W-2:0], d_i}, m_q)) begin
        m_q    <= ~m_q;
        m_rise <= ~m_q;
        m_fall <= m_q;
      end
    end
  end

  wire [3:0] obs = {q_o, notq_o, rise_o, fall_o};
  wire [3:0] mdl = {m_q, ~m_q, m_rise, m_fall};

  task automatic test_reset();
    logic [3:0] want;
    d_i   = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== 4'b0100) begin
        bad++;
        $display("FAIL reset_hold c=%0d: q/nq/r/f got %b want 0100", c, obs);
      end
    end
    #4 rst_n = 1'b1;
    for (int e = 1; e <= LAT + 3; e++) begin
      @(posedge clk); #1;
      want = {e >= LAT, e < LAT, e == LAT, 1'b0};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset_release e=%0d: q/nq/r/f got %b want %b", e, obs, want);
      end
    end
  endtask

  task automatic test_clean_fall();
    logic [3:0] want;
    #4 d_i = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      want = {e < LAT, e >= LAT, 1'b0, e == LAT};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL clean_fall e=%0d: q/nq/r/f got %b want %b", e, obs, want);
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [3:0] want;
    #4 d_i = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      want = {e >= LAT, e < LAT, e == LAT, 1'b0};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL clean_rise e=%0d: q/nq/r/f got %b want %b", e, obs, want);
      end
    end
  endtask

  task automatic test_glitch();
    // A run one sample short of qualifying must be rejected.
    for (int c = 0; c < 11; c++) begin
      #4 d_i = (c < STABLE - 1);
      @(posedge clk); #1;
      total++;
      if (obs !== 4'b0100) begin
        bad++;
        $display("FAIL glitch_short c=%0d: q/nq/r/f got %b want 0100", c, obs);
      end
    end
    for (int p = 0; p < 8; p++) begin
      #($urandom_range(1, 8)) d_i = 1'b1;
      #10 d_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        total++;
        if (obs !== 4'b0100) begin
          bad++;
          $display("FAIL glitch_pulse p=%0d c=%0d: q/nq/r/f got %b want 0100", p, c, obs);
        end
      end
    end
  endtask

  task automatic test_random();
    logic v;
    int   len;
    for (int s = 0; s < 60; s++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        if (c == 0) begin
          #($urandom_range(1, 7)) d_i = v;
        end
        @(posedge clk); #1;
        total++;
        if (obs !== mdl) begin
          bad++;
          $display("FAIL random s=%0d c=%0d: q/nq/r/f got %b want %b", s, c, obs, mdl);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] want;
    int         n_rise;
    n_rise = 0;
    #4 d_i = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== mdl) begin
        bad++;
        $display("FAIL bounce_settle c=%0d: q/nq/r/f got %b want %b", c, obs, mdl);
      end
    end
    for (int i = 0; i < 8; i++) begin
      #4 d_i = (i % 2 == 0);
      @(posedge clk); #1;
      n_rise += int'(rise_o);
      total++;
      if (obs !== 4'b0100) begin
        bad++;
        $display("FAIL bounce_toggle i=%0d: q/nq/r/f got %b want 0100", i, obs);
      end
    end
    #4 d_i = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      n_rise += int'(rise_o);
      want = {e >= LAT, e < LAT, e == LAT, 1'b0};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL bounce_hold e=%0d: q/nq/r/f got %b want %b", e, obs, want);
      end
    end
    total++;
    if (n_rise !== 1) begin
      bad++;
      $display("FAIL bounce_rise_count: got %0d want 1", n_rise);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    #4 d_i = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== mdl) begin
        bad++;
        $display("FAIL mid_settle c=%0d: q/nq/r/f got %b want %b", c, obs, mdl);
      end
    end
    // Four edges after the change puts the FSM in S_RISE with cnt=2.
    #4 d_i = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== 4'b0100) begin
        bad++;
        $display("FAIL mid_count e=%0d: q/nq/r/f got %b want 0100", e, obs);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (obs !== 4'b0100) begin
        bad++;
        $display("FAIL mid_async p=%0d: q/nq/r/f got %b want 0100", pass, obs);
      end
      for (int c = 0; c < 2; c++) begin
        @(posedge clk); #1;
        total++;
        if (obs !== 4'b0100) begin
          bad++;
          $display("FAIL mid_hold p=%0d c=%0d: q/nq/r/f got %b want 0100", pass, c, obs);
        end
      end
      #4 rst_n = 1'b1;
      for (int e = 1; e <= LAT + 2; e++) begin
        @(posedge clk); #1;
        want = {e >= LAT, e < LAT, e == LAT, 1'b0};
        total++;
        if (obs !== want) begin
          bad++;
          $display("FAIL mid_release p=%0d e=%0d: q/nq/r/f got %b want %b", pass, e, obs, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_fall();
    test_glitch();
    test_clean_rise();
    test_random();
    test_bounce();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
